shift_seq: RTL and testbench
============================

# shift_seq

Command sequencer that sits directly upstream of the team's 4-bit universal shift register and drives its mode-select, parallel-load and serial-fill inputs. A single command loads a word, then shifts it a programmed number of places in one direction with a chosen fill bit. The block keeps a mirror of the downstream register contents and reports each bit as it is shifted out. Its outputs connect one-to-one to the shift register's `p`, `s`, `sr`, `sl` inputs and share its `clk`/`reset`.

## Interface
- `W`, default 4: data width, matching the downstream register width.
- `CW`, default `$clog2(W+1)`: width of the shift-count field.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: sequencer idle; a command is accepted on `cmd_valid & cmd_ready`.
- `cmd_data` in W: word to parallel-load.
- `cmd_dir` in 1: 0 = shift right (fill enters MSB via `sr`); 1 = shift left (fill enters LSB via `sl`).
- `cmd_len` in CW: number of shifts, 0..W. Values above W are clamped to W.
- `cmd_fill` in 1: serial fill bit for every shift of this command.
- `s` out 2: mode to the shift register (00 hold, 01 shift right, 10 shift left, 11 load).
- `p` out W: parallel load data.
- `sr`, `sl` out 1 each: serial inputs.
- `ser_out` out 1: bit leaving the register at the end of the current shift cycle.
- `ser_valid` out 1: `ser_out` is meaningful.
- `q_mirror` out W: predicted downstream register contents.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle pulse when a command completes.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE. Outputs are decoded from registered state and operand registers (Moore), so the downstream register samples them on the same edge on which the FSM advances.
- **IDLE**
  - `cmd_ready`=1, `s`=00, `busy`=0.
  - On accept: capture data, direction, clamped length and fill; go to LOAD.
- **LOAD** (1 cycle)
  - `s`=11, `p`=captured data.
  - `q_mirror` takes the data at the end of the cycle.
  - Go to DONE if len=0, otherwise go to SHIFT.
- **SHIFT** (len cycles)
  - Right: `s`=01, `sr`=fill, `sl`=0, `ser_out`=`q_mirror[0]`; mirror becomes {fill, mirror[W-1:1]}.
  - Left: `s`=10, `sl`=fill, `sr`=0, `ser_out`=`q_mirror[W-1]`; mirror becomes {mirror[W-2:0], fill}.
  - `ser_valid`=1 in every SHIFT cycle.
  - A down-counter loaded with len decrements each cycle; go to DONE after the cycle in which the counter equals 1.
- **DONE** (1 cycle)
  - `done`=1, `s`=00; go to IDLE.
- `busy`=1 in LOAD, SHIFT and DONE.
- `cmd_valid` is ignored whenever `cmd_ready`=0. No command is queued.
- `p` holds its last loaded value outside LOAD. `sr`/`sl` are 0 outside SHIFT.

## Timing
- Reset values:
  - state IDLE, `s`=00, `p`=0, `sr`=`sl`=0.
  - `ser_out`=0, `ser_valid`=0, `q_mirror`=0.
  - `busy`=0, `done`=0.
  - `cmd_ready`=0 while `reset` is high; 1 in the first cycle after release.
- Accept on edge k:
  - LOAD is cycle k+1.
  - SHIFT occupies cycles k+2 .. k+1+len.
  - DONE is cycle k+2+len.
  - `cmd_ready`=1 in cycle k+3+len.
- Back-to-back: a command held on `cmd_valid` is accepted at the end of the first IDLE cycle. Minimum spacing between accepts is len+3 cycles.
- Reset asserted mid-command:
  - Aborts the command; all reset values apply the following cycle.
  - No `done` pulse is issued.
  - `q_mirror` clears to 0, matching the downstream register, which shares the same reset.
- len=W: the whole word is shifted out. With len=W and fill=f, `q_mirror` ends as all f.
- All counter arithmetic is unsigned, CW bits. Clamping happens at accept, so the counter never exceeds W.

## Structure
- Shared package `shift_pkg` holds:
  - mode constants `MODE_HOLD`=2'b00, `MODE_SHR`=2'b01, `MODE_SHL`=2'b10, `MODE_LOAD`=2'b11;
  - the FSM state enum;
  - the direction encoding `DIR_RIGHT`=0, `DIR_LEFT`=1.
  
  The downstream register bench uses the same mode constants.
- One sub-module, `shift_mirror`: a W-bit register with load/shift-right/shift-left/hold controlled by `s`, plus fill inputs. It produces `q_mirror` and the outgoing bit. The FSM and counter stay in `shift_seq`.

## Test plan
1. Hold `reset` for 2 cycles, then release → all outputs at reset values during reset; `cmd_ready`=1 the cycle after release; `s`=00.
2. Command data=1000, dir=0, len=2, fill=1 → one cycle `s`=11 with `p`=1000; two cycles `s`=01 with `sr`=1 and `ser_out`=0,0; `q_mirror`=1110; `done` in cycle k+4.
3. Command data=1001, dir=1, len=3, fill=0 → `s`=10 for 3 cycles with `sl`=0; `ser_out`=1,0,0; final `q_mirror`=1000; `busy` high for 5 cycles.
4. Command len=0, data=1010 → LOAD then DONE directly; `ser_valid` never asserts; `q_mirror`=1010; `done` in cycle k+2.
5. Command len=7, data=0110, dir=0, fill=0 with `cmd_valid` held high throughout → clamped to 4 shifts (`ser_out`=0,1,1,0); `q_mirror`=0000; second command accepted exactly in cycle k+7; no command accepted while `busy`.
6. Assert `reset` during the 2nd SHIFT cycle of a len=4 command → next cycle `s`=00, `q_mirror`=0, `busy`=0; no `done` pulse; a new command is accepted normally after release.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the shift sequencer and the downstream universal shift register.
package shift_pkg;
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;
endpackage

// File: rtl/shift_mirror.sv
// Shadow copy of the downstream universal shift register, driven by the same mode/fill inputs.
module shift_mirror
  import shift_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   s,
  input  logic [W-1:0] p,
  input  logic         sr,
  input  logic         sl,
  output logic [W-1:0] q,
  output logic         ser_out
);
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else begin
      case (s)
        MODE_LOAD: q <= p;
        MODE_SHR:  q <= {sr, q[W-1:1]};
        MODE_SHL:  q <= {q[W-2:0], sl};
        default:   q <= q;
      endcase
    end
  end

  // Bit that falls off the register on this edge; zero when not shifting.
  always_comb begin
    ser_out = 1'b0;
    case (s)
      MODE_SHR: ser_out = q[0];
      MODE_SHL: ser_out = q[W-1];
      default:  ser_out = 1'b0;
    endcase
  end
endmodule

// File: rtl/shift_seq.sv
// Load-then-shift command sequencer driving a universal shift register's s/p/sr/sl inputs.
module shift_seq
  import shift_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = $clog2(W+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [W-1:0]  cmd_data,
  input  logic          cmd_dir,
  input  logic [CW-1:0] cmd_len,
  input  logic          cmd_fill,
  output logic [1:0]    s,
  output logic [W-1:0]  p,
  output logic          sr,
  output logic          sl,
  output logic          ser_out,
  output logic          ser_valid,
  output logic [W-1:0]  q_mirror,
  output logic          busy,
  output logic          done
);
  state_e        state_q, state_d;
  logic [W-1:0]  data_q;
  logic          dir_q, fill_q;
  logic [CW-1:0] cnt_q, cnt_d, len_clamp;
  logic          accept;

  assign cmd_ready = (state_q == ST_IDLE) & ~reset;
  assign accept    = cmd_valid & cmd_ready;
  assign len_clamp = (cmd_len > CW'(W)) ? CW'(W) : cmd_len;
  assign p         = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      dir_q   <= DIR_RIGHT;
      fill_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= cmd_data;
        dir_q  <= cmd_dir;
        fill_q <= cmd_fill;
        cnt_q  <= len_clamp;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s         = MODE_HOLD;
    sr        = 1'b0;
    sl        = 1'b0;
    ser_valid = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (accept) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        s       = MODE_LOAD;
        state_d = (cnt_q == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        s         = (dir_q == DIR_LEFT) ? MODE_SHL : MODE_SHR;
        sr        = (dir_q == DIR_RIGHT) & fill_q;
        sl        = (dir_q == DIR_LEFT) & fill_q;
        ser_valid = 1'b1;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  shift_mirror #(.W(W)) u_mirror (
    .clk     (clk),
    .reset   (reset),
    .s       (s),
    .p       (p),
    .sr      (sr),
    .sl      (sl),
    .q       (q_mirror),
    .ser_out (ser_out)
  );
endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: stimulus queues expected per-cycle activity, a monitor checks it.
module tb_shift_seq;
  localparam int W  = 4;
  localparam int CW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_dir, cmd_fill;
  logic [W-1:0]  cmd_data;
  logic [CW-1:0] cmd_len;
  logic [1:0]    s;
  logic [W-1:0]  p, q_mirror;
  logic          sr, sl, ser_out, ser_valid, busy, done;

  shift_seq #(.W(W), .CW(CW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_dir(cmd_dir), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
    .s(s), .p(p), .sr(sr), .sl(sl), .ser_out(ser_out), .ser_valid(ser_valid),
    .q_mirror(q_mirror), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] s;
    logic [3:0] p;
    logic       sr, sl, sv, so, dn;
    logic [3:0] q;
  } rec_t;

  rec_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;
  int   last_busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any non-idle cycle must match the next queued expectation.
  always @(negedge clk) begin
    rec_t o, e;
    if (busy) busy_cnt = busy_cnt + 1;
    else if (busy_cnt > 0) begin last_busy = busy_cnt; busy_cnt = 0; end
    if (s != 2'b00 || done || ser_valid) begin
      o.cyc = cyc; o.s = s; o.p = (s == 2'b11) ? p : 4'h0;
      o.sr = sr; o.sl = sl; o.sv = ser_valid; o.so = ser_out; o.dn = done;
      o.q = done ? q_mirror : 4'h0;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_activity cyc=%0d got s=%b p=%b sr=%b sl=%b sv=%b so=%b done=%b q=%b, required none",
                 o.cyc, o.s, o.p, o.sr, o.sl, o.sv, o.so, o.dn, o.q);
      end else begin
        e = exp_q.pop_front();
        if (o.cyc != e.cyc || {o.s, o.p, o.sr, o.sl, o.sv, o.so, o.dn, o.q} !==
                              {e.s, e.p, e.sr, e.sl, e.sv, e.so, e.dn, e.q}) begin
          n_fail++;
          $display("FAIL activity got cyc=%0d s=%b p=%b sr=%b sl=%b sv=%b so=%b done=%b q=%b required cyc=%0d s=%b p=%b sr=%b sl=%b sv=%b so=%b done=%b q=%b",
                   o.cyc, o.s, o.p, o.sr, o.sl, o.sv, o.so, o.dn, o.q,
                   e.cyc, e.s, e.p, e.sr, e.sl, e.sv, e.so, e.dn, e.q);
        end
      end
    end
  end

  task automatic push_load(input int c, input logic [3:0] d);
    rec_t r;
    r = '{cyc: c, s: 2'b11, p: d, sr: 0, sl: 0, sv: 0, so: 0, dn: 0, q: 4'h0};
    exp_q.push_back(r);
  endtask

  task automatic push_shift(input int c, input logic dir, input logic fill, input logic so);
    rec_t r;
    r = '{cyc: c, s: dir ? 2'b10 : 2'b01, p: 4'h0, sr: !dir & fill, sl: dir & fill,
          sv: 1, so: so, dn: 0, q: 4'h0};
    exp_q.push_back(r);
  endtask

  task automatic push_done(input int c, input logic [3:0] q);
    rec_t r;
    r = '{cyc: c, s: 2'b00, p: 4'h0, sr: 0, sl: 0, sv: 0, so: 0, dn: 1, q: q};
    exp_q.push_back(r);
  endtask

  task automatic check(input string name, input int got, input int req);
    n_chk++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // Offer a command; returns k such that cycle k+1 is the LOAD cycle.
  task automatic send(input logic [3:0] d, input logic dir, input logic [CW-1:0] len,
                      input logic fill, input logic hold, output int k);
    logic acc;
    bit   ok = 0;
    cmd_data = d; cmd_dir = dir; cmd_len = len; cmd_fill = fill; cmd_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      acc = cmd_ready;
      @(posedge clk); #1;
      if (acc) begin ok = 1; break; end
    end
    k = cyc - 1;
    if (!hold) cmd_valid = 1'b0;
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout got=not_accepted required=accepted");
      k = -100;
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (!busy && exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL %s_idle_timeout got=busy/pending(%0d) required=idle", name, exp_q.size());
    end
    @(negedge clk); #1;
  endtask

  task automatic check_reset_vals(input string name);
    check(name, int'({s, p, sr, sl, ser_out, ser_valid, q_mirror, busy, done, cmd_ready}), 0);
  endtask

  initial begin
    int k, k2;
    reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_dir = 1'b0; cmd_len = '0; cmd_fill = 1'b0;

    // 1: reset values, ready the cycle after release
    @(posedge clk); #1; check_reset_vals("reset_c1");
    @(posedge clk); #1; check_reset_vals("reset_c2");
    reset = 1'b0; #1;
    check("ready_after_release", int'(cmd_ready), 1);
    check("mode_after_release", int'(s), 0);

    // 2: right shift by 2, fill 1
    send(4'b1000, 1'b0, 3'd2, 1'b1, 1'b0, k);
    push_load(k+1, 4'b1000);
    push_shift(k+2, 1'b0, 1'b1, 1'b0);
    push_shift(k+3, 1'b0, 1'b1, 1'b0);
    push_done(k+4, 4'b1110);
    wait_idle("t2");

    // 3: left shift by 3, fill 0
    send(4'b1001, 1'b1, 3'd3, 1'b0, 1'b0, k);
    push_load(k+1, 4'b1001);
    push_shift(k+2, 1'b1, 1'b0, 1'b1);
    push_shift(k+3, 1'b1, 1'b0, 1'b0);
    push_shift(k+4, 1'b1, 1'b0, 1'b0);
    push_done(k+5, 4'b1000);
    wait_idle("t3");
    check("t3_busy_cycles", last_busy, 5);

    // 4: zero-length command goes LOAD -> DONE
    send(4'b1010, 1'b0, 3'd0, 1'b0, 1'b0, k);
    push_load(k+1, 4'b1010);
    push_done(k+2, 4'b1010);
    wait_idle("t4");

    // 5: len 7 clamps to 4, valid held so the next command lands back-to-back
    send(4'b0110, 1'b0, 3'd7, 1'b0, 1'b1, k);
    push_load(k+1, 4'b0110);
    push_shift(k+2, 1'b0, 1'b0, 1'b0);
    push_shift(k+3, 1'b0, 1'b0, 1'b1);
    push_shift(k+4, 1'b0, 1'b0, 1'b1);
    push_shift(k+5, 1'b0, 1'b0, 1'b0);
    push_done(k+6, 4'b0000);
    send(4'b0001, 1'b1, 3'd1, 1'b1, 1'b0, k2);
    check("t5_second_accept_edge", k2, k + 7);
    push_load(k2+1, 4'b0001);
    push_shift(k2+2, 1'b1, 1'b1, 1'b0);
    push_done(k2+3, 4'b0011);
    wait_idle("t5");

    // 6: reset in the 2nd SHIFT cycle aborts without a done pulse
    send(4'b0101, 1'b1, 3'd4, 1'b1, 1'b0, k);
    push_load(k+1, 4'b0101);
    push_shift(k+2, 1'b1, 1'b1, 1'b0);
    push_shift(k+3, 1'b1, 1'b1, 1'b1);
    while (cyc < k + 3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("t6_after_abort");
    reset = 1'b0; #1;
    check("t6_ready_after_release", int'(cmd_ready), 1);
    send(4'b0011, 1'b0, 3'd1, 1'b0, 1'b0, k);
    push_load(k+1, 4'b0011);
    push_shift(k+2, 1'b0, 1'b0, 1'b1);
    push_done(k+3, 4'b0001);
    wait_idle("t6");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
